// File: rtl/can_rx_frame_ctrl.sv
// CAN 2.0 receive frame sequencer: bus-idle/SOF detection, bit destuffing,
// IDE/RTR/DLC capture and frame-length tracking up to the CRC field.
module can_rx_frame_ctrl #(
    parameter int unsigned clk_speed_MHz      = 100,
    parameter int unsigned can_bit_rate_Kbits = 1000,
    parameter int unsigned IDLE_BITS          = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       sample_dout,
    input  logic       sample_dvalid,
    output logic       sample_en,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       frame_start,
    output logic       crc_start,
    output logic       stuff_err,
    output logic       crc_stuff_next,
    output logic       ide,
    output logic       rtr,
    output logic [3:0] dlc,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
    localparam int unsigned IDLE_CYCLES  = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W       = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned POS_W        = 7;
    localparam int unsigned RUN_W        = 3;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        ARMED     = 2'd1,
        RECV      = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_d;
    logic [POS_W-1:0]   pos, pos_d;
    logic [RUN_W-1:0]   run_len, run_len_d;
    logic               run_val, run_val_d;
    logic               sof_pending, sof_pending_d;

    logic       sample_en_d, bit_out_d, bit_valid_d, frame_start_d;
    logic       crc_start_d, stuff_err_d, crc_stuff_next_d;
    logic       ide_d, rtr_d, busy_d;
    logic [3:0] dlc_d;

    // Destuffed bit count from the first ID bit to the last data bit.
    function automatic logic [POS_W-1:0] frame_len(input logic f_ide, input logic f_rtr,
                                                   input logic [3:0] f_dlc);
        logic [POS_W-1:0] hdr;
        logic [POS_W-1:0] data;
        hdr = f_ide ? POS_W'(38) : POS_W'(18);
        if (f_rtr) begin
            data = '0;
        end else if (f_dlc[3]) begin
            data = POS_W'(64);
        end else begin
            data = POS_W'({f_dlc[2:0], 3'b000});
        end
        return hdr + data;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state;
        idle_cnt_d       = idle_cnt;
        pos_d            = pos;
        run_len_d        = run_len;
        run_val_d        = run_val;
        sof_pending_d    = sof_pending;
        sample_en_d      = sample_en;
        bit_out_d        = bit_out;
        bit_valid_d      = 1'b0;
        frame_start_d    = 1'b0;
        crc_start_d      = 1'b0;
        stuff_err_d      = 1'b0;
        crc_stuff_next_d = 1'b0;
        ide_d            = ide;
        rtr_d            = rtr;
        dlc_d            = dlc;

        case (state)
            WAIT_IDLE: begin
                if (!din) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = ARMED;
                end else begin
                    idle_cnt_d = idle_cnt + IDLE_W'(1);
                end
            end

            ARMED: begin
                if (!din) begin
                    state_d       = RECV;
                    frame_start_d = 1'b1;
                    sample_en_d   = 1'b1;
                    pos_d         = '0;
                    run_len_d     = '0;
                    run_val_d     = 1'b0;
                    sof_pending_d = 1'b1;
                    ide_d         = 1'b0;
                    rtr_d         = 1'b0;
                    dlc_d         = '0;
                end
            end

            RECV: begin
                if (sample_dvalid) begin
                    if (sof_pending) begin
                        if (!sample_dout) begin
                            sof_pending_d = 1'b0;
                            run_val_d     = 1'b0;
                            run_len_d     = RUN_W'(1);
                        end else begin
                            state_d     = WAIT_IDLE;
                            sample_en_d = 1'b0;
                        end
                    end else if (run_len == RUN_W'(5)) begin
                        // Stuff bit: must oppose the run, never forwarded.
                        if (sample_dout != run_val) begin
                            run_val_d = sample_dout;
                            run_len_d = RUN_W'(1);
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = WAIT_IDLE;
                            sample_en_d = 1'b0;
                        end
                    end else begin
                        run_len_d   = (sample_dout == run_val) ? run_len + RUN_W'(1) : RUN_W'(1);
                        run_val_d   = sample_dout;
                        pos_d       = pos + POS_W'(1);
                        bit_out_d   = sample_dout;
                        bit_valid_d = 1'b1;

                        if (pos_d == POS_W'(12)) rtr_d = sample_dout;
                        if (pos_d == POS_W'(13)) ide_d = sample_dout;
                        if (!ide && pos_d >= POS_W'(15) && pos_d <= POS_W'(18)) begin
                            dlc_d = {dlc[2:0], sample_dout};
                        end
                        if (ide && pos_d == POS_W'(32)) rtr_d = sample_dout;
                        if (ide && pos_d >= POS_W'(35) && pos_d <= POS_W'(38)) begin
                            dlc_d = {dlc[2:0], sample_dout};
                        end

                        if (pos_d == frame_len(ide_d, rtr_d, dlc_d)) begin
                            crc_start_d      = 1'b1;
                            crc_stuff_next_d = (run_len_d == RUN_W'(5));
                            state_d          = WAIT_IDLE;
                            sample_en_d      = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d     = WAIT_IDLE;
                idle_cnt_d  = '0;
                sample_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d == RECV);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_IDLE;
            idle_cnt       <= '0;
            pos            <= '0;
            run_len        <= '0;
            run_val        <= 1'b0;
            sof_pending    <= 1'b0;
            sample_en      <= 1'b0;
            bit_out        <= 1'b0;
            bit_valid      <= 1'b0;
            frame_start    <= 1'b0;
            crc_start      <= 1'b0;
            stuff_err      <= 1'b0;
            crc_stuff_next <= 1'b0;
            ide            <= 1'b0;
            rtr            <= 1'b0;
            dlc            <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            idle_cnt       <= idle_cnt_d;
            pos            <= pos_d;
            run_len        <= run_len_d;
            run_val        <= run_val_d;
            sof_pending    <= sof_pending_d;
            sample_en      <= sample_en_d;
            bit_out        <= bit_out_d;
            bit_valid      <= bit_valid_d;
            frame_start    <= frame_start_d;
            crc_start      <= crc_start_d;
            stuff_err      <= stuff_err_d;
            crc_stuff_next <= crc_stuff_next_d;
            ide            <= ide_d;
            rtr            <= rtr_d;
            dlc            <= dlc_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: doc/can_rx_frame_ctrl.md
# can_rx_frame_ctrl

Receive-side frame sequencer for the CAN 2.0 receiver. It watches the raw rx line for bus idle and a start-of-frame edge, then enables the bit sampler and consumes its sampled bits. It removes stuff bits, decodes IDE/RTR/DLC to track the frame length, and deasserts the sampler enable exactly at the start of the CRC field. Downstream blocks get a destuffed header/data bitstream plus frame control flags.

## Interface
- clk_speed_MHz, 100, system clock frequency in MHz
- can_bit_rate_Kbits, 1000, CAN bit rate in kbit/s; CLKS_PER_BIT = clk_speed_MHz*1000/can_bit_rate_Kbits
- IDLE_BITS, 11, consecutive recessive bit times required before SOF is accepted
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  raw rx line (already synchronized); 1 = recessive
- sample_dout  input  1  sampled bit from the bit sampler
- sample_dvalid  input  1  one-cycle strobe; sample_dout is valid in the same cycle
- sample_en  output  1  sampler enable; high from SOF until CRC field start
- bit_out  output  1  destuffed bit (SOF excluded)
- bit_valid  output  1  one-cycle strobe for bit_out
- frame_start  output  1  one-cycle pulse on accepted SOF edge
- crc_start  output  1  one-cycle pulse when the last data bit is accepted
- stuff_err  output  1  one-cycle pulse on stuff violation
- crc_stuff_next  output  1  valid with crc_start: 1 if the next bus bit is a stuff bit
- ide, rtr  output  1 each  captured frame flags
- dlc  output  4  captured DLC
- busy  output  1  high in RECV

## Operation
- States: WAIT_IDLE, ARMED, RECV. Reset enters WAIT_IDLE.
- WAIT_IDLE: an idle counter (width $clog2(IDLE_BITS*CLKS_PER_BIT+1)) increments on each cycle with din=1 and clears on din=0. Reaching IDLE_BITS*CLKS_PER_BIT moves to ARMED.
- ARMED: the first cycle with din=0 moves to RECV. frame_start pulses, sample_en rises, and the bit/stuff counters and ide/rtr/dlc clear.
- RECV, first sample_dvalid (SOF check):
  - sample_dout=0 is the SOF bit. It seeds the stuff run (value 0, length 1) and is not output.
  - sample_dout=1 is a false start. Drop sample_en and return to WAIT_IDLE. No pulses are issued.
- RECV stuff tracking:
  - Track the run value and run length over all bus bits, stuff bits included.
  - When the run length reaches 5, the next bit is a stuff bit.
  - A stuff bit of opposite value is discarded (no bit_valid) and restarts the run at length 1.
  - A stuff bit of equal value pulses stuff_err, drops sample_en, and returns to WAIT_IDLE.
- Non-stuff bits increment a 7-bit destuffed position n (1-based after SOF) and are emitted on bit_out/bit_valid.
- Field capture:
  - n=12 captures rtr provisionally (this is SRR if extended).
  - n=13 captures ide.
  - If ide=0, DLC is bits 15–18.
  - If ide=1, bit 32 overwrites rtr and DLC is bits 35–38.
- End of frame:
  - Header length H = 18 (ide=0) or 38 (ide=1).
  - Data bits D = 0 if rtr=1, else 8*min(dlc,8).
  - When n reaches H+D (bit accepted), pulse crc_start, drop sample_en, and go to WAIT_IDLE.
  - crc_stuff_next = (run length == 5) after that bit.
- ide/rtr/dlc hold until the next frame_start.
- sample_dvalid outside RECV is ignored.

## Timing
- Reset values: all outputs 0.
- Reset is asynchronous. Reset mid-frame drops sample_en at once, returns to WAIT_IDLE, and requires the full idle time again.
- frame_start and sample_en rise on the clock edge after the first din=0 cycle in ARMED.
- bit_out/bit_valid, stuff_err, and crc_start are registered: one cycle after the causing sample_dvalid.
- sample_en falls in that same cycle. crc_start and the final bit_valid coincide.
- ide/rtr/dlc update in the cycle their final bit's bit_valid is asserted.
- At most one of crc_start/stuff_err per frame. A stuff violation on the bit that would complete the frame gives stuff_err only.
- DLC values 9–15 are held as received; D saturates at 64. Maximum n = 102.
- A din=0 during WAIT_IDLE restarts the idle count. No SOF is accepted until the count completes.

## Test plan
- Standard data frame, ID 0x123, DLC 2, data 0xA5 0x5A, with correct stuffing → frame_start once; exactly 34 bit_valid pulses; ide=0, rtr=0, dlc=2; crc_start with the 34th bit; sample_en low the next cycle.
- ID 0x000 (SOF + four 0 ID bits, then stuff 1) → no bit_valid for the stuff bit; ID bits out all 0; frame completes normally.
- Same frame with the stuff bit forced to 0 → stuff_err one cycle after that sample_dvalid; sample_en drops; no crc_start; next SOF ignored until 11 idle bit times.
- Extended remote frame, IDE=1, RTR=1, DLC 3 → 38 bit_valid pulses, rtr=1, dlc=3, crc_start on bit 38.
- din low after only 5 recessive bit times, and a 10-cycle glitch after a full idle → no frame_start in the first case; in the glitch case SOF samples 1, giving a false start with no pulses and a return to WAIT_IDLE.
- rst_n low mid-data field → all outputs 0 immediately; frame_start only after 1100 cycles of din=1 followed by a falling edge.
